// File: rtl/gray_bin_conv_pipe_if.sv
// Handshake bundle for gray_bin_conv_pipe.
// slave  : converter side (accepts input words, produces output words).
// master : environment side (drives input words, consumes output words).
interface gray_bin_conv_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] xfer_cnt;
  logic             adj_err;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, xfer_cnt, adj_err
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, xfer_cnt, adj_err
  );
endinterface

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides.
// in_mode = 0 converts Gray->binary, in_mode = 1 converts binary->Gray.
// The Gray->binary prefix-XOR chain is split across the STAGES registers,
// MSB side first; binary->Gray is a single XOR level done in the first stage.
// The whole pipeline holds while the output word is stalled.
// Optional macro GRAY_ADJ_CHECK_EN adds a Hamming-distance check between
// consecutive Gray-mode input words, reported on adj_err.
module gray_bin_conv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  gray_bin_conv_pipe_if.slave bus
);

  // Number of prefix-XOR bit positions resolved per stage (ceiling division).
  localparam int CHUNK = (WIDTH - 1 + STAGES - 1) / STAGES;

  // One stage worth of conversion work on a partially converted word.
  // For Gray->binary, bits above the stage's chunk are already binary and
  // bits below are still Gray; bit WIDTH-1 needs no work.
  function automatic logic [WIDTH-1:0] conv_step(input logic [WIDTH-1:0] r_in,
                                                 input logic mode,
                                                 input int stage);
    logic [WIDTH-1:0] r;
    r = r_in;
    if (mode) begin
      if (stage == 0) r = r_in ^ (r_in >> 1);
    end else begin
      for (int i = WIDTH - 2; i >= 0; i--) begin
        if (((WIDTH - 2 - i) / CHUNK) == stage) r[i] = r[i+1] ^ r[i];
      end
    end
    return r;
  endfunction

  logic [WIDTH-1:0] data_p [STAGES];
  logic             mode_p [STAGES];
  logic             vld_p  [STAGES];
  logic [CNT_W-1:0] xfer_cnt_q;
  logic             stall;
  logic             accept;

  assign stall         = vld_p[STAGES-1] & ~bus.out_ready;
  assign accept        = bus.in_valid & ~stall;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.out_mode  = mode_p[STAGES-1];
  assign bus.out_data  = data_p[STAGES-1];
  assign bus.xfer_cnt  = xfer_cnt_q;

  // Pipeline registers: all stages advance together unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_p[s]  <= 1'b0;
        mode_p[s] <= 1'b0;
        data_p[s] <= '0;
      end
    end else if (!stall) begin
      vld_p[0]  <= bus.in_valid;
      mode_p[0] <= bus.in_mode;
      data_p[0] <= conv_step(bus.in_data, bus.in_mode, 0);
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s]  <= vld_p[s-1];
        mode_p[s] <= mode_p[s-1];
        data_p[s] <= conv_step(data_p[s-1], mode_p[s-1], s);
      end
    end
  end

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else if (accept) begin
      xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
    end
  end

`ifdef GRAY_ADJ_CHECK_EN
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [CW-1:0] ones(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic             adj_err_q;

  // Compare each Gray-mode accept with the previous Gray-mode accept; one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
      adj_err_q <= 1'b0;
    end else begin
      adj_err_q <= 1'b0;
      if (accept && !bus.in_mode) begin
        if (have_prev && (ones(bus.in_data ^ prev_gray) > CW'(1))) adj_err_q <= 1'b1;
        prev_gray <= bus.in_data;
        have_prev <= 1'b1;
      end
    end
  end

  assign bus.adj_err = adj_err_q;
`else
  assign bus.adj_err = 1'b0;
`endif

endmodule
